// File: rtl/awg_mode_sequencer.sv
// Slow amplitude/waveform sequencer feeding the AWG formula: sweep up, dwell, sweep down, next mode.
// All outputs registered on clk_tick_led; enable=0 aborts to reset values, hold=1 freezes everything but mode_change.
module awg_mode_sequencer #(
  parameter int NUM_MODES   = 4,
  parameter int AMP_MIN     = 32,
  parameter int AMP_MAX     = 224,
  parameter int AMP_STEP    = 32,
  parameter int DWELL_TICKS = 4
) (
  input  logic       clk_tick_led,
  input  logic       rst,
  input  logic       enable,
  input  logic       hold,
  output logic [1:0] wave_sel,
  output logic [7:0] amplitude,
  output logic [7:0] phase_inc,
  output logic       mode_change,
  output logic       led
);

  localparam int DW = $clog2(DWELL_TICKS + 1);

  // Amplitude math is 9 bits wide so a ceiling of 255 saturates instead of wrapping.
  localparam logic [8:0]    LP_MIN        = 9'(AMP_MIN);
  localparam logic [8:0]    LP_MAX        = 9'(AMP_MAX);
  localparam logic [8:0]    LP_STEP       = 9'(AMP_STEP);
  localparam logic [8:0]    LP_DN_THR     = 9'(AMP_MIN + AMP_STEP);
  localparam logic [DW-1:0] LP_DWELL_LAST = DW'(DWELL_TICKS - 1);
  localparam logic [1:0]    LP_LAST_MODE  = 2'(NUM_MODES - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SWEEP_UP   = 3'd1,
    S_DWELL      = 3'd2,
    S_SWEEP_DOWN = 3'd3,
    S_NEXT       = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_wave_sel, w_wave_sel_nxt;
  logic [7:0]    r_amp, w_amp_nxt;
  logic [7:0]    r_phase_inc, w_phase_inc_nxt;
  logic          r_mode_change, w_mode_change_nxt;
  logic          r_led, w_led_nxt;
  logic [DW-1:0] r_dwell_cnt, w_dwell_cnt_nxt;

  logic [8:0]    w_amp_up;
  logic [7:0]    w_amp_dn;

  assign w_amp_up = {1'b0, r_amp} + LP_STEP;
  assign w_amp_dn = r_amp - 8'(AMP_STEP);

  always_ff @(posedge clk_tick_led or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_wave_sel    <= 2'd0;
      r_amp         <= LP_MIN[7:0];
      r_phase_inc   <= 8'd1;
      r_mode_change <= 1'b0;
      r_led         <= 1'b0;
      r_dwell_cnt   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_wave_sel    <= w_wave_sel_nxt;
      r_amp         <= w_amp_nxt;
      r_phase_inc   <= w_phase_inc_nxt;
      r_mode_change <= w_mode_change_nxt;
      r_led         <= w_led_nxt;
      r_dwell_cnt   <= w_dwell_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = S_IDLE;
    end else if (r_state == S_IDLE) begin
      w_state_nxt = S_SWEEP_UP;
    end else if (!hold) begin
      case (r_state)
        S_SWEEP_UP:   if (w_amp_up >= LP_MAX) w_state_nxt = S_DWELL;
        S_DWELL:      if (r_dwell_cnt == LP_DWELL_LAST) w_state_nxt = S_SWEEP_DOWN;
        S_SWEEP_DOWN: if ({1'b0, r_amp} <= LP_DN_THR) w_state_nxt = S_NEXT;
        S_NEXT:       w_state_nxt = S_SWEEP_UP;
        default:      w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs; IDLE and abort both load reset values.
  always_comb begin
    w_wave_sel_nxt    = r_wave_sel;
    w_amp_nxt         = r_amp;
    w_phase_inc_nxt   = r_phase_inc;
    w_mode_change_nxt = 1'b0;
    w_led_nxt         = r_led;
    w_dwell_cnt_nxt   = r_dwell_cnt;
    if (!enable || r_state == S_IDLE) begin
      w_wave_sel_nxt  = 2'd0;
      w_amp_nxt       = LP_MIN[7:0];
      w_phase_inc_nxt = 8'd1;
      w_led_nxt       = 1'b0;
      w_dwell_cnt_nxt = '0;
    end else if (!hold) begin
      w_led_nxt = ~r_led;
      case (r_state)
        S_SWEEP_UP: begin
          if (w_amp_up >= LP_MAX) begin
            w_amp_nxt       = LP_MAX[7:0];
            w_dwell_cnt_nxt = '0;
          end else begin
            w_amp_nxt = w_amp_up[7:0];
          end
        end
        S_DWELL: w_dwell_cnt_nxt = r_dwell_cnt + 1'b1;
        S_SWEEP_DOWN: begin
          if ({1'b0, r_amp} <= LP_DN_THR) w_amp_nxt = LP_MIN[7:0];
          else                            w_amp_nxt = w_amp_dn;
        end
        S_NEXT: begin
          w_mode_change_nxt = 1'b1;
          if (r_wave_sel == LP_LAST_MODE) begin
            w_wave_sel_nxt  = 2'd0;
            w_phase_inc_nxt = 8'd1;
          end else begin
            w_wave_sel_nxt  = r_wave_sel + 2'd1;
            w_phase_inc_nxt = r_phase_inc << 1;
          end
        end
        default: ;
      endcase
    end
  end

  assign wave_sel    = r_wave_sel;
  assign amplitude   = r_amp;
  assign phase_inc   = r_phase_inc;
  assign mode_change = r_mode_change;
  assign led         = r_led;

endmodule

// File: tb/tb_awg_mode_sequencer.sv
// Directed bench for awg_mode_sequencer: default instance plus a saturating-ceiling instance.
module tb_awg_mode_sequencer;

  logic       clk_tick_led = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       hold = 1'b0;
  logic [1:0] wave_sel, wave_sel2;
  logic [7:0] amplitude, amplitude2;
  logic [7:0] phase_inc, phase_inc2;
  logic       mode_change, mode_change2;
  logic       led, led2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk_tick_led = ~clk_tick_led;

  awg_mode_sequencer dut (
    .clk_tick_led(clk_tick_led), .rst(rst), .enable(enable), .hold(hold),
    .wave_sel(wave_sel), .amplitude(amplitude), .phase_inc(phase_inc),
    .mode_change(mode_change), .led(led)
  );

  awg_mode_sequencer #(.AMP_MIN(0), .AMP_MAX(255), .AMP_STEP(64)) dut_sat (
    .clk_tick_led(clk_tick_led), .rst(rst), .enable(enable), .hold(hold),
    .wave_sel(wave_sel2), .amplitude(amplitude2), .phase_inc(phase_inc2),
    .mode_change(mode_change2), .led(led2)
  );

  typedef struct {
    int wave;
    int amp;
    int ph;
    int mc;
    int led;
  } vec_t;

  vec_t vecs[19];
  int   sat_amp[13];
  int   exp_wave[4];
  int   exp_ph[4];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_tick_led);
    @(negedge clk_tick_led);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    hold = 1'b0;
    @(negedge clk_tick_led);
    @(negedge clk_tick_led);
    rst = 1'b0;
  endtask

  task automatic chk_outs(input string name, input int w, input int a, input int p, input int m, input int l);
    chk({name, ".wave_sel"}, int'(wave_sel), w);
    chk({name, ".amplitude"}, int'(amplitude), a);
    chk({name, ".phase_inc"}, int'(phase_inc), p);
    chk({name, ".mode_change"}, int'(mode_change), m);
    chk({name, ".led"}, int'(led), l);
  endtask

  initial begin
    int np;
    // edges 1..19 from enable=1 with defaults: {wave, amp, phase, mode_change, led}
    vecs[0]  = '{0,  32, 1, 0, 0};
    vecs[1]  = '{0,  64, 1, 0, 1};
    vecs[2]  = '{0,  96, 1, 0, 0};
    vecs[3]  = '{0, 128, 1, 0, 1};
    vecs[4]  = '{0, 160, 1, 0, 0};
    vecs[5]  = '{0, 192, 1, 0, 1};
    vecs[6]  = '{0, 224, 1, 0, 0};
    vecs[7]  = '{0, 224, 1, 0, 1};
    vecs[8]  = '{0, 224, 1, 0, 0};
    vecs[9]  = '{0, 224, 1, 0, 1};
    vecs[10] = '{0, 224, 1, 0, 0};
    vecs[11] = '{0, 192, 1, 0, 1};
    vecs[12] = '{0, 160, 1, 0, 0};
    vecs[13] = '{0, 128, 1, 0, 1};
    vecs[14] = '{0,  96, 1, 0, 0};
    vecs[15] = '{0,  64, 1, 0, 1};
    vecs[16] = '{0,  32, 1, 0, 0};
    vecs[17] = '{1,  32, 2, 1, 1};
    vecs[18] = '{1,  64, 2, 0, 0};
    sat_amp = '{0, 64, 128, 192, 255, 255, 255, 255, 255, 191, 127, 63, 0};
    exp_wave = '{1, 2, 3, 0};
    exp_ph   = '{2, 4, 8, 1};

    // reset state
    do_reset();
    chk_outs("reset", 0, 32, 1, 0, 0);
    chk("reset.state", int'(dut.r_state), 0);

    // first mode, edge by edge
    enable = 1'b1;
    for (int e = 0; e < 19; e++) begin
      step();
      chk_outs($sformatf("vec%0d", e + 1), vecs[e].wave, vecs[e].amp, vecs[e].ph, vecs[e].mc, vecs[e].led);
    end

    // four full modes: wave_sel / phase_inc progression and single-cycle pulses
    do_reset();
    enable = 1'b1;
    step();
    np = 0;
    for (int e = 2; e <= 71; e++) begin
      step();
      if (mode_change) begin
        chk("modes.pulse_edge", e, 18 + 17 * np);
        if (np < 4) begin
          chk("modes.wave_sel", int'(wave_sel), exp_wave[np]);
          chk("modes.phase_inc", int'(phase_inc), exp_ph[np]);
        end
        np++;
      end
    end
    chk("modes.pulse_count", np, 4);

    // hold for 3 edges at amplitude 128 during the up-sweep
    do_reset();
    enable = 1'b1;
    steps(4);
    chk("hold.pre_amp", int'(amplitude), 128);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold.amp", int'(amplitude), 128);
      chk("hold.led", int'(led), 1);
      chk("hold.state", int'(dut.r_state), 1);
      chk("hold.dwell_cnt", int'(dut.r_dwell_cnt), 0);
    end
    hold = 1'b0;
    step();
    chk("hold.release_amp", int'(amplitude), 160);
    chk("hold.release_led", int'(led), 0);

    // enable dropped in the second mode's dwell with dwell_cnt=2
    do_reset();
    enable = 1'b1;
    steps(26);
    chk("abort.pre_state", int'(dut.r_state), 2);
    chk("abort.pre_dwell", int'(dut.r_dwell_cnt), 2);
    chk_outs("abort.pre", 1, 224, 2, 0, 1);
    enable = 1'b0;
    step();
    chk_outs("abort", 0, 32, 1, 0, 0);
    chk("abort.state", int'(dut.r_state), 0);
    enable = 1'b1;
    step();
    chk("reen.e1_amp", int'(amplitude), 32);
    chk("reen.e1_state", int'(dut.r_state), 1);
    step();
    chk("reen.e2_amp", int'(amplitude), 64);

    // asynchronous reset while in the second mode's NEXT state
    do_reset();
    enable = 1'b1;
    steps(34);
    chk("arst.pre_state", int'(dut.r_state), 4);
    chk_outs("arst.pre", 1, 32, 2, 0, 1);
    #2 rst = 1'b1;
    #1;
    chk_outs("arst.now", 0, 32, 1, 0, 0);
    chk("arst.state", int'(dut.r_state), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("arst.no_pulse", int'(mode_change), 0);
      chk("arst.wave_sel", int'(wave_sel), 0);
    end
    chk("arst.amp_e3", int'(amplitude), 96);

    // saturating instance: AMP_MIN=0, AMP_MAX=255, AMP_STEP=64
    do_reset();
    enable = 1'b1;
    for (int e = 0; e < 13; e++) begin
      step();
      chk($sformatf("sat.amp_e%0d", e + 1), int'(amplitude2), sat_amp[e]);
    end
    step();
    chk("sat.next_wave", int'(wave_sel2), 1);
    chk("sat.next_mc", int'(mode_change2), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
